// File: rtl/univ_rotate_seq_reg.sv
// univ_rotate_seq_reg
//   Universal shift/rotate register. It takes a variable step amount and has four modes:
//   rotate, logical, arithmetic and serial-fill. It keeps the last shifted-out bit. An
//   optional counted auto-step sequencer adds a busy/done handshake.
//
// Configuration macro:
//   UNIV_ROTATE_SEQ_EN  defined: the sequencer (RUN state, start/count/busy/done) is built.
//                       undefined: start/count are ignored and busy/done are tied low.
//
// Ports:
//   clk       in   rising-edge clock
//   sync_rst  in   synchronous active-high reset
//   ctrl      in   00 load, 10 step left, 01 step right, 11 hold
//   mode      in   00 rotate, 01 logical, 10 arithmetic, 11 serial (fill from sin)
//   amt       in   bits moved per step
//   sin       in   fill bit for serial mode (always live, also during a sequencer run)
//   data      in   parallel load value
//   start     in   launch the sequencer (accepted in idle only)
//   count     in   number of steps for a sequencer run
//   q         out  register contents
//   sout      out  last bit shifted out
//   busy      out  sequencer running
//   done      out  one-cycle completion pulse
module univ_rotate_seq_reg #(
    parameter int unsigned DW = 8,
    parameter int unsigned AW = 3,
    parameter int unsigned CW = 8
) (
    input  logic          clk,
    input  logic          sync_rst,
    input  logic [1:0]    ctrl,
    input  logic [1:0]    mode,
    input  logic [AW-1:0] amt,
    input  logic          sin,
    input  logic [DW-1:0] data,
    input  logic          start,
    input  logic [CW-1:0] count,
    output logic [DW-1:0] q,
    output logic          sout,
    output logic          busy,
    output logic          done
);

    localparam logic [1:0] CtrlLoad  = 2'b00;
    localparam logic [1:0] CtrlRight = 2'b01;
    localparam logic [1:0] CtrlLeft  = 2'b10;
    localparam logic [1:0] CtrlHold  = 2'b11;

    localparam logic [1:0] ModeRot   = 2'b00;
    localparam logic [1:0] ModeLog   = 2'b01;
    localparam logic [1:0] ModeArith = 2'b10;
    localparam logic [1:0] ModeSer   = 2'b11;

    // One step of the register. Returns {new_sout, new_q}. A zero amount leaves both unchanged.
    function automatic logic [DW:0] step_fn(
        input logic [DW-1:0] v,
        input logic          left,
        input logic [1:0]    md,
        input logic [AW-1:0] k,
        input logic          fill,
        input logic          so_in
    );
        logic [2*DW-1:0]        dbl;
        logic [DW-1:0]          res;
        logic [DW-1:0]          ones;
        logic [DW-1:0]          mask;
        logic [DW-1:0]          tap;
        logic signed [DW-1:0]   sv;
        logic                   so;
        int unsigned            kk;
        int unsigned            kr;
        kk   = 32'(k);
        kr   = kk % DW;
        ones = '1;
        dbl  = '0;
        mask = '0;
        tap  = '0;
        sv   = v;
        res  = v;
        so   = so_in;
        if (kk != 0) begin
            case (md)
                ModeRot: begin
                    // Shifting a doubled copy gives the rotate with no special case for kr=0.
                    if (left) begin
                        dbl = {v, v} << kr;
                        res = dbl[2*DW-1:DW];
                    end else begin
                        dbl = {v, v} >> kr;
                        res = dbl[DW-1:0];
                    end
                end
                ModeLog: begin
                    if (left) res = v << kk;
                    else      res = v >> kk;
                end
                ModeArith: begin
                    if (left) res = v << kk;
                    else      res = sv >>> kk;
                end
                default: begin
                    if (left) begin
                        mask = ~(ones << kk);
                        res  = (v << kk) | ({DW{fill}} & mask);
                    end else begin
                        mask = ~(ones >> kk);
                        res  = (v >> kk) | ({DW{fill}} & mask);
                    end
                end
            endcase

            if (md != ModeRot) begin
                if (kk >= DW) begin
                    if (md == ModeLog)                 so = 1'b0;
                    else if (md == ModeArith && !left) so = v[DW-1];
                    else if (left)                     so = v[0];
                    else                               so = v[DW-1];
                end else begin
                    if (left) tap = v >> (DW - kk);
                    else      tap = v >> (kk - 1);
                    so = tap[0];
                end
            end
        end
        return {so, res};
    endfunction

    logic [DW-1:0] q_q, q_d;
    logic          sout_q, sout_d;

    // Operation applied this cycle: live inputs in idle, latched ones during a run.
    logic [1:0]    step_ctrl;
    logic [1:0]    step_mode;
    logic [AW-1:0] step_amt;
    logic          apply;
    logic          load_ok;

`ifdef UNIV_ROTATE_SEQ_EN
    typedef enum logic [0:0] {StIdle, StRun} state_e;

    state_e        state_q, state_d;
    logic [1:0]    ctrl_lq, ctrl_ld;
    logic [1:0]    mode_lq, mode_ld;
    logic [AW-1:0] amt_lq, amt_ld;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          done_q, done_d;

    always_comb begin
        state_d   = state_q;
        ctrl_ld   = ctrl_lq;
        mode_ld   = mode_lq;
        amt_ld    = amt_lq;
        cnt_d     = cnt_q;
        done_d    = 1'b0;
        step_ctrl = ctrl;
        step_mode = mode;
        step_amt  = amt;
        apply     = 1'b1;
        load_ok   = 1'b1;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    // The launch edge never touches q.
                    apply = 1'b0;
                    if (count != '0) begin
                        ctrl_ld = ctrl;
                        mode_ld = mode;
                        amt_ld  = amt;
                        cnt_d   = count;
                        state_d = StRun;
                    end else begin
                        done_d  = 1'b1;
                    end
                end
            end
            StRun: begin
                step_ctrl = ctrl_lq;
                step_mode = mode_lq;
                step_amt  = amt_lq;
                // A latched load behaves as hold for the length of the run.
                load_ok   = 1'b0;
                cnt_d     = cnt_q - 1'b1;
                if (cnt_q == CW'(1)) begin
                    state_d = StIdle;
                    done_d  = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (sync_rst) begin
            state_q <= StIdle;
            ctrl_lq <= CtrlHold;
            mode_lq <= ModeRot;
            amt_lq  <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ctrl_lq <= ctrl_ld;
            mode_lq <= mode_ld;
            amt_lq  <= amt_ld;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
        end
    end

    assign busy = (state_q == StRun);
    assign done = done_q;
`else
    logic unused_seq;

    always_comb begin
        step_ctrl = ctrl;
        step_mode = mode;
        step_amt  = amt;
        apply     = 1'b1;
        load_ok   = 1'b1;
    end

    assign unused_seq = ^{start, count};
    assign busy       = 1'b0;
    assign done       = 1'b0;
`endif

    always_comb begin
        q_d    = q_q;
        sout_d = sout_q;
        if (apply) begin
            unique case (step_ctrl)
                CtrlLoad:  if (load_ok) q_d = data;
                CtrlLeft:  {sout_d, q_d} = step_fn(q_q, 1'b1, step_mode, step_amt, sin, sout_q);
                CtrlRight: {sout_d, q_d} = step_fn(q_q, 1'b0, step_mode, step_amt, sin, sout_q);
                CtrlHold:  ;
                default:   ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (sync_rst) begin
            q_q    <= '0;
            sout_q <= 1'b0;
        end else begin
            q_q    <= q_d;
            sout_q <= sout_d;
        end
    end

    assign q    = q_q;
    assign sout = sout_q;

endmodule

// File: tb/tb_univ_rotate_seq_reg.sv
// Directed bench for univ_rotate_seq_reg (DW=8, AW=3, CW=8).
// Sequencer scenarios are exercised when UNIV_ROTATE_SEQ_EN is defined; otherwise the bench
// checks that start/count are ignored and busy/done stay low.
module tb_univ_rotate_seq_reg;

    logic       clk = 1'b0;
    logic       sync_rst = 1'b1;
    logic [1:0] ctrl = 2'b11;
    logic [1:0] mode = 2'b00;
    logic [2:0] amt = 3'd0;
    logic       sin = 1'b0;
    logic [7:0] data = 8'h00;
    logic       start = 1'b0;
    logic [7:0] count = 8'd0;
    logic [7:0] q;
    logic       sout;
    logic       busy;
    logic       done;

    int checks = 0;
    int errors = 0;

    univ_rotate_seq_reg #(.DW(8), .AW(3), .CW(8)) dut (
        .clk      (clk),
        .sync_rst (sync_rst),
        .ctrl     (ctrl),
        .mode     (mode),
        .amt      (amt),
        .sin      (sin),
        .data     (data),
        .start    (start),
        .count    (count),
        .q        (q),
        .sout     (sout),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input logic [7:0] v);
        start = 1'b0;
        ctrl  = 2'b00;
        data  = v;
        tick();
    endtask

    task automatic test_reset();
        sync_rst = 1'b1;
        tick();
        sync_rst = 1'b0;
        do_load(8'h80);
        mode = 2'b01; ctrl = 2'b10; amt = 3'd1;
        tick();
        do_load(8'h5A);
        checks++; if (q !== 8'h5A) begin errors++; $display("FAIL pre_rst_q: got %h want 5a", q); end
        checks++; if (sout !== 1'b1) begin errors++; $display("FAIL pre_rst_sout: got %b want 1", sout); end
        sync_rst = 1'b1; ctrl = 2'b00; data = 8'hA5;
        #2;
        checks++; if (q !== 8'h5A) begin errors++; $display("FAIL rst_before_edge: got %h want 5a", q); end
        tick();
        checks++; if (q !== 8'h00) begin errors++; $display("FAIL rst_q: got %h want 00", q); end
        checks++; if (sout !== 1'b0) begin errors++; $display("FAIL rst_sout: got %b want 0", sout); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b want 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL rst_done: got %b want 0", done); end
        sync_rst = 1'b0;
    endtask

    task automatic test_rotate();
        do_load(8'hB4);
        checks++; if (q !== 8'hB4) begin errors++; $display("FAIL load_b4: got %h want b4", q); end
        mode = 2'b00; ctrl = 2'b10; amt = 3'd3;
        tick();
        checks++; if (q !== 8'hA5) begin errors++; $display("FAIL rotl3: got %h want a5", q); end
        ctrl = 2'b01;
        tick();
        checks++; if (q !== 8'hB4) begin errors++; $display("FAIL rotr3: got %h want b4", q); end
        ctrl = 2'b10; amt = 3'd0;
        tick();
        checks++; if (q !== 8'hB4) begin errors++; $display("FAIL rot_amt0: got %h want b4", q); end
    endtask

    task automatic test_shifts();
        do_load(8'h90);
        mode = 2'b10; ctrl = 2'b01; amt = 3'd2;
        tick();
        checks++; if (q !== 8'hE4) begin errors++; $display("FAIL asr2_q: got %h want e4", q); end
        checks++; if (sout !== 1'b0) begin errors++; $display("FAIL asr2_sout: got %b want 0", sout); end
        do_load(8'h90);
        mode = 2'b01; ctrl = 2'b01; amt = 3'd2;
        tick();
        checks++; if (q !== 8'h24) begin errors++; $display("FAIL lsr2_q: got %h want 24", q); end
        do_load(8'h9F);
        mode = 2'b01; ctrl = 2'b10; amt = 3'd4;
        tick();
        checks++; if (q !== 8'hF0) begin errors++; $display("FAIL lsl4_q: got %h want f0", q); end
        checks++; if (sout !== 1'b1) begin errors++; $display("FAIL lsl4_sout: got %b want 1", sout); end
        amt = 3'd0;
        tick();
        checks++; if (q !== 8'hF0) begin errors++; $display("FAIL lsl0_q: got %h want f0", q); end
        checks++; if (sout !== 1'b1) begin errors++; $display("FAIL lsl0_sout: got %b want 1", sout); end
        ctrl = 2'b11; amt = 3'd2;
        tick();
        checks++; if (q !== 8'hF0) begin errors++; $display("FAIL hold_q: got %h want f0", q); end
    endtask

    task automatic test_serial();
        do_load(8'h00);
        mode = 2'b11; sin = 1'b1; ctrl = 2'b10; amt = 3'd1;
        for (int i = 0; i < 4; i++) tick();
        checks++; if (q !== 8'h0F) begin errors++; $display("FAIL ser_l_q: got %h want 0f", q); end
        checks++; if (sout !== 1'b0) begin errors++; $display("FAIL ser_l_sout: got %b want 0", sout); end
        sin = 1'b0; ctrl = 2'b01; amt = 3'd3;
        tick();
        checks++; if (q !== 8'h01) begin errors++; $display("FAIL ser_r_q: got %h want 01", q); end
        checks++; if (sout !== 1'b1) begin errors++; $display("FAIL ser_r_sout: got %b want 1", sout); end
        sin = 1'b0;
    endtask

`ifdef UNIV_ROTATE_SEQ_EN
    task automatic test_sequencer();
        logic [7:0] exp;
        do_load(8'h01);
        mode = 2'b00; ctrl = 2'b10; amt = 3'd1; start = 1'b1; count = 8'd5;
        tick();
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL seq_e0_busy: got %b want 1", busy); end
        checks++; if (q !== 8'h01) begin errors++; $display("FAIL seq_e0_q: got %h want 01", q); end
        start = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            ctrl = (i == 5) ? 2'b11 : ((i % 2) != 0 ? 2'b01 : 2'b00);
            mode = 2'b01; amt = 3'd3; data = 8'hFF;
            tick();
            exp = 8'h01 << i;
            checks++; if (q !== exp) begin errors++; $display("FAIL seq_step%0d_q: got %h want %h", i, q, exp); end
            checks++; if (busy !== (i < 5)) begin errors++; $display("FAIL seq_step%0d_busy: got %b", i, busy); end
            checks++; if (done !== (i == 5)) begin errors++; $display("FAIL seq_step%0d_done: got %b", i, done); end
        end
        tick();
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL seq_done_pulse: got %b want 0", done); end
        checks++; if (q !== 8'h20) begin errors++; $display("FAIL seq_hold_q: got %h want 20", q); end
        start = 1'b1; count = 8'd0;
        tick();
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL cnt0_done: got %b want 1", done); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL cnt0_busy: got %b want 0", busy); end
        checks++; if (q !== 8'h20) begin errors++; $display("FAIL cnt0_q: got %h want 20", q); end
        start = 1'b0;
        tick();
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL cnt0_done_end: got %b want 0", done); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL cnt0_busy_end: got %b want 0", busy); end
    endtask

    task automatic test_back_to_back();
        do_load(8'h01);
        mode = 2'b00; ctrl = 2'b10; amt = 3'd1; start = 1'b1; count = 8'd2;
        tick();
        start = 1'b0;
        tick();
        tick();
        checks++; if (q !== 8'h04) begin errors++; $display("FAIL b2b_run1_q: got %h want 04", q); end
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL b2b_run1_done: got %b want 1", done); end
        start = 1'b1; count = 8'd1; ctrl = 2'b01; amt = 3'd2;
        tick();
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL b2b_run2_busy: got %b want 1", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL b2b_run2_done0: got %b want 0", done); end
        start = 1'b0; ctrl = 2'b11;
        tick();
        checks++; if (q !== 8'h01) begin errors++; $display("FAIL b2b_run2_q: got %h want 01", q); end
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL b2b_run2_done: got %b want 1", done); end
        tick();
    endtask

    task automatic test_reset_midrun();
        do_load(8'h01);
        mode = 2'b00; ctrl = 2'b10; amt = 3'd1; start = 1'b1; count = 8'd5;
        tick();
        start = 1'b0;
        tick();
        tick();
        checks++; if (q !== 8'h04) begin errors++; $display("FAIL midrst_pre_q: got %h want 04", q); end
        sync_rst = 1'b1;
        tick();
        sync_rst = 1'b0; ctrl = 2'b11;
        checks++; if (q !== 8'h00) begin errors++; $display("FAIL midrst_q: got %h want 00", q); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy: got %b want 0", busy); end
        for (int i = 0; i < 4; i++) begin
            checks++; if (done !== 1'b0) begin errors++; $display("FAIL midrst_done%0d: got %b want 0", i, done); end
            tick();
        end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy_end: got %b want 0", busy); end
    endtask
`else
    task automatic test_no_sequencer();
        do_load(8'h01);
        start = 1'b1; count = 8'd5; ctrl = 2'b11;
        tick();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL noseq_busy: got %b want 0", busy); end
        checks++; if (q !== 8'h01) begin errors++; $display("FAIL noseq_hold_q: got %h want 01", q); end
        mode = 2'b00; ctrl = 2'b10; amt = 3'd1;
        tick();
        checks++; if (q !== 8'h02) begin errors++; $display("FAIL noseq_step_q: got %h want 02", q); end
        ctrl = 2'b11; start = 1'b0;
        tick();
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL noseq_done: got %b want 0", done); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL noseq_busy_end: got %b want 0", busy); end
    endtask
`endif

    initial begin
        test_reset();
        test_rotate();
        test_shifts();
        test_serial();
`ifdef UNIV_ROTATE_SEQ_EN
        test_sequencer();
        test_back_to_back();
        test_reset_midrun();
`else
        test_no_sequencer();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
